// File: rtl/ctrl_pipe.sv
// ctrl_pipe: D->E->M->W control/address pipeline with flush/stall and optional load-use detection.
// Latency: one cycle per stage; writereg_e is combinational from E registers.
// Backpressure: stall holds a stage and feeds bubbles downstream; flush beats stall. Macro: CTRL_PIPE_LOADUSE_EN.
module ctrl_pipe #(
  parameter int ALUCTRL_W = 8,
  parameter int REG_AW    = 5
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 valid_d,
  input  logic [9:0]           ctrl_d,
  input  logic [ALUCTRL_W-1:0] alucontrol_d,
  input  logic [REG_AW-1:0]    rs_d,
  input  logic [REG_AW-1:0]    rt_d,
  input  logic [REG_AW-1:0]    rd_d,
  input  logic                 stall_e,
  input  logic                 flush_e,
  input  logic                 stall_m,
  input  logic                 flush_m,
  input  logic                 flush_w,
  output logic                 valid_e,
  output logic                 valid_m,
  output logic                 valid_w,
  output logic [9:0]           ctrl_e,
  output logic [9:0]           ctrl_m,
  output logic [9:0]           ctrl_w,
  output logic [ALUCTRL_W-1:0] alucontrol_e,
  output logic [REG_AW-1:0]    rs_e,
  output logic [REG_AW-1:0]    rt_e,
  output logic [REG_AW-1:0]    writereg_e,
  output logic [REG_AW-1:0]    writereg_m,
  output logic [REG_AW-1:0]    writereg_w,
  output logic                 lwstall
);

  // Control bit positions within the 10-bit ctrl word.
  localparam int C_MEMTOREG = 9;
  localparam int C_REGDST   = 5;
  localparam int C_REGWRITE = 4;
  localparam int C_JAL      = 2;
  localparam int C_BAL      = 0;

  // E stage
  logic                 r_valid_e;
  logic [9:0]           r_ctrl_e;
  logic [ALUCTRL_W-1:0] r_alucontrol_e;
  logic [REG_AW-1:0]    r_rs_e;
  logic [REG_AW-1:0]    r_rt_e;
  logic [REG_AW-1:0]    r_rd_e;
  // M stage
  logic                 r_valid_m;
  logic [9:0]           r_ctrl_m;
  logic [REG_AW-1:0]    r_writereg_m;
  // W stage
  logic                 r_valid_w;
  logic [9:0]           r_ctrl_w;
  logic [REG_AW-1:0]    r_writereg_w;

  logic [REG_AW-1:0]    w_writereg_e;
  logic                 w_lwstall;
  logic                 w_flush_e;

  // Destination select: link register for jal/bal, else rd or rt by regdst.
  always_comb begin
    w_writereg_e = r_rt_e;
    if (r_ctrl_e[C_JAL] | r_ctrl_e[C_BAL]) begin
      w_writereg_e = '1;
    end else if (r_ctrl_e[C_REGDST]) begin
      w_writereg_e = r_rd_e;
    end
  end

`ifdef CTRL_PIPE_LOADUSE_EN
  // A load in E whose destination is read by D must bubble E for one cycle.
  assign w_lwstall = r_valid_e & r_ctrl_e[C_MEMTOREG] & r_ctrl_e[C_REGWRITE]
                   & (w_writereg_e != '0)
                   & ((w_writereg_e == rs_d) | (w_writereg_e == rt_d));
  assign w_flush_e = flush_e | w_lwstall;
`else
  assign w_lwstall = 1'b0;
  assign w_flush_e = flush_e;
`endif

  // E stage register: flush > stall > load from D.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid_e      <= 1'b0;
      r_ctrl_e       <= '0;
      r_alucontrol_e <= '0;
      r_rs_e         <= '0;
      r_rt_e         <= '0;
      r_rd_e         <= '0;
    end else if (w_flush_e) begin
      r_valid_e      <= 1'b0;
      r_ctrl_e       <= '0;
      r_alucontrol_e <= '0;
      r_rs_e         <= '0;
      r_rt_e         <= '0;
      r_rd_e         <= '0;
    end else if (!stall_e) begin
      r_valid_e      <= valid_d;
      r_ctrl_e       <= ctrl_d;
      r_alucontrol_e <= alucontrol_d;
      r_rs_e         <= rs_d;
      r_rt_e         <= rt_d;
      r_rd_e         <= rd_d;
    end
  end

  // M stage register: flush > stall > bubble when E is held > load from E.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid_m    <= 1'b0;
      r_ctrl_m     <= '0;
      r_writereg_m <= '0;
    end else if (flush_m) begin
      r_valid_m    <= 1'b0;
      r_ctrl_m     <= '0;
      r_writereg_m <= '0;
    end else if (stall_m) begin
      r_valid_m    <= r_valid_m;
    end else if (stall_e) begin
      r_valid_m    <= 1'b0;
      r_ctrl_m     <= '0;
      r_writereg_m <= '0;
    end else begin
      r_valid_m    <= r_valid_e;
      r_ctrl_m     <= r_ctrl_e;
      r_writereg_m <= w_writereg_e;
    end
  end

  // W stage register: never stalls; bubble on flush or when M is held.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid_w    <= 1'b0;
      r_ctrl_w     <= '0;
      r_writereg_w <= '0;
    end else if (flush_w || stall_m) begin
      r_valid_w    <= 1'b0;
      r_ctrl_w     <= '0;
      r_writereg_w <= '0;
    end else begin
      r_valid_w    <= r_valid_m;
      r_ctrl_w     <= r_ctrl_m;
      r_writereg_w <= r_writereg_m;
    end
  end

  // Controls are masked by stage valid so empty stages never act.
  assign valid_e      = r_valid_e;
  assign valid_m      = r_valid_m;
  assign valid_w      = r_valid_w;
  assign ctrl_e       = r_ctrl_e & {10{r_valid_e}};
  assign ctrl_m       = r_ctrl_m & {10{r_valid_m}};
  assign ctrl_w       = r_ctrl_w & {10{r_valid_w}};
  assign alucontrol_e = r_alucontrol_e;
  assign rs_e         = r_rs_e;
  assign rt_e         = r_rt_e;
  assign writereg_e   = w_writereg_e;
  assign writereg_m   = r_writereg_m;
  assign writereg_w   = r_writereg_w;
  assign lwstall      = w_lwstall;

endmodule

// File: tb/tb_ctrl_pipe.sv
// tb_ctrl_pipe: directed vectors for ctrl_pipe with hand-computed expectations.
// Latency: checks sampled 1 time unit after each rising edge.
// Backpressure: exercises stall/flush precedence and reset mid-stream.
module tb_ctrl_pipe;

  logic       clk;
  logic       rst;
  logic       valid_d;
  logic [9:0] ctrl_d;
  logic [7:0] alucontrol_d;
  logic [4:0] rs_d, rt_d, rd_d;
  logic       stall_e, flush_e, stall_m, flush_m, flush_w;
  logic       valid_e, valid_m, valid_w;
  logic [9:0] ctrl_e, ctrl_m, ctrl_w;
  logic [7:0] alucontrol_e;
  logic [4:0] rs_e, rt_e, writereg_e, writereg_m, writereg_w;
  logic       lwstall;

  int total = 0;
  int bad   = 0;

  ctrl_pipe #(.ALUCTRL_W(8), .REG_AW(5)) dut (
    .clk(clk), .rst(rst), .valid_d(valid_d), .ctrl_d(ctrl_d),
    .alucontrol_d(alucontrol_d), .rs_d(rs_d), .rt_d(rt_d), .rd_d(rd_d),
    .stall_e(stall_e), .flush_e(flush_e), .stall_m(stall_m),
    .flush_m(flush_m), .flush_w(flush_w),
    .valid_e(valid_e), .valid_m(valid_m), .valid_w(valid_w),
    .ctrl_e(ctrl_e), .ctrl_m(ctrl_m), .ctrl_w(ctrl_w),
    .alucontrol_e(alucontrol_e), .rs_e(rs_e), .rt_e(rt_e),
    .writereg_e(writereg_e), .writereg_m(writereg_m), .writereg_w(writereg_w),
    .lwstall(lwstall)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [9:0] c, input logic [7:0] a,
                       input logic [4:0] s, input logic [4:0] t, input logic [4:0] d);
    valid_d = v; ctrl_d = c; alucontrol_d = a; rs_d = s; rt_d = t; rd_d = d;
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_valid_e"}, {31'd0, valid_e}, 32'd0);
    chk({tag, "_valid_m"}, {31'd0, valid_m}, 32'd0);
    chk({tag, "_valid_w"}, {31'd0, valid_w}, 32'd0);
    chk({tag, "_ctrl_e"}, {22'd0, ctrl_e}, 32'd0);
    chk({tag, "_ctrl_m"}, {22'd0, ctrl_m}, 32'd0);
    chk({tag, "_ctrl_w"}, {22'd0, ctrl_w}, 32'd0);
    chk({tag, "_wreg_e"}, {27'd0, writereg_e}, 32'd0);
    chk({tag, "_wreg_m"}, {27'd0, writereg_m}, 32'd0);
    chk({tag, "_wreg_w"}, {27'd0, writereg_w}, 32'd0);
  endtask

  // ctrl encodings: memtoreg=0x200 memen=0x100 regdst=0x020 regwrite=0x010 jal=0x004
  initial begin
    logic exp_lw;
    rst = 1'b0;
    drive(1'b0, 10'h000, 8'h00, 5'd0, 5'd0, 5'd0);
    stall_e = 0; flush_e = 0; stall_m = 0; flush_m = 0; flush_w = 0;
    #2 rst = 1'b1;
    #1 check_all_zero("reset");
    chk("reset_lwstall", {31'd0, lwstall}, 32'd0);
    step(); step();
    rst = 1'b0;

    // rd vs rt selection
    drive(1'b1, 10'h030, 8'h2A, 5'd1, 5'd3, 5'd9);
    step();
    chk("rd_sel_valid_e", {31'd0, valid_e}, 32'd1);
    chk("rd_sel_ctrl_e", {22'd0, ctrl_e}, 32'h030);
    chk("rd_sel_wreg_e", {27'd0, writereg_e}, 32'd9);
    chk("rd_sel_aluc_e", {24'd0, alucontrol_e}, 32'h2A);
    chk("rd_sel_rs_e", {27'd0, rs_e}, 32'd1);
    chk("rd_sel_rt_e", {27'd0, rt_e}, 32'd3);
    drive(1'b1, 10'h010, 8'h11, 5'd2, 5'd4, 5'd9);
    step();
    chk("rt_sel_wreg_e", {27'd0, writereg_e}, 32'd4);
    chk("rt_sel_wreg_m", {27'd0, writereg_m}, 32'd9);
    chk("rt_sel_ctrl_m", {22'd0, ctrl_m}, 32'h030);

    // jal overrides regdst
    drive(1'b1, 10'h034, 8'h00, 5'd0, 5'd2, 5'd7);
    step();
    chk("jal_wreg_e", {27'd0, writereg_e}, 32'd31);
    drive(1'b0, 10'h3FF, 8'hFF, 5'd0, 5'd0, 5'd0);
    step();
    chk("jal_wreg_m", {27'd0, writereg_m}, 32'd31);
    chk("invalid_ctrl_e", {22'd0, ctrl_e}, 32'h000);
    chk("invalid_valid_e", {31'd0, valid_e}, 32'd0);
    drive(1'b0, 10'h000, 8'h00, 5'd0, 5'd0, 5'd0);
    step();
    chk("jal_wreg_w", {27'd0, writereg_w}, 32'd31);
    chk("jal_ctrl_w", {22'd0, ctrl_w}, 32'h034);
    chk("jal_valid_w", {31'd0, valid_w}, 32'd1);

    // stall_e for two cycles: E holds, M gets bubbles
    drive(1'b1, 10'h110, 8'h05, 5'd0, 5'd6, 5'd0);
    step();
    drive(1'b1, 10'h020, 8'h07, 5'd12, 5'd13, 5'd11);
    stall_e = 1'b1;
    step();
    chk("stall1_ctrl_e", {22'd0, ctrl_e}, 32'h110);
    chk("stall1_wreg_e", {27'd0, writereg_e}, 32'd6);
    chk("stall1_valid_m", {31'd0, valid_m}, 32'd0);
    chk("stall1_ctrl_m", {22'd0, ctrl_m}, 32'h000);
    step();
    chk("stall2_aluc_e", {24'd0, alucontrol_e}, 32'h05);
    chk("stall2_valid_m", {31'd0, valid_m}, 32'd0);
    chk("stall2_valid_w", {31'd0, valid_w}, 32'd0);
    stall_e = 1'b0;
    step();
    chk("resume_valid_m", {31'd0, valid_m}, 32'd1);
    chk("resume_ctrl_m", {22'd0, ctrl_m}, 32'h110);
    chk("resume_wreg_m", {27'd0, writereg_m}, 32'd6);
    chk("resume_wreg_e", {27'd0, writereg_e}, 32'd11);

    // stall_e and flush_e together: flush wins
    drive(1'b1, 10'h010, 8'h09, 5'd3, 5'd3, 5'd3);
    stall_e = 1'b1; flush_e = 1'b1;
    step();
    chk("flushwin_valid_e", {31'd0, valid_e}, 32'd0);
    chk("flushwin_ctrl_e", {22'd0, ctrl_e}, 32'h000);
    chk("flushwin_aluc_e", {24'd0, alucontrol_e}, 32'h00);
    chk("flushwin_rs_e", {27'd0, rs_e}, 32'd0);
    chk("flushwin_rt_e", {27'd0, rt_e}, 32'd0);
    stall_e = 1'b0; flush_e = 1'b0;

    // stall_m holds M and bubbles W; flush_m beats stall_m
    drive(1'b1, 10'h010, 8'h00, 5'd0, 5'd14, 5'd0);
    step();
    drive(1'b0, 10'h000, 8'h00, 5'd0, 5'd0, 5'd0);
    step();
    chk("mload_wreg_m", {27'd0, writereg_m}, 32'd14);
    stall_m = 1'b1;
    step();
    chk("mstall_valid_m", {31'd0, valid_m}, 32'd1);
    chk("mstall_wreg_m", {27'd0, writereg_m}, 32'd14);
    chk("mstall_valid_w", {31'd0, valid_w}, 32'd0);
    flush_m = 1'b1;
    step();
    chk("mflush_valid_m", {31'd0, valid_m}, 32'd0);
    stall_m = 1'b0; flush_m = 1'b0;

    // load-use: load writing r5 in E, rs_d=5 in D
    drive(1'b1, 10'h210, 8'h00, 5'd0, 5'd5, 5'd0);
    step();
    drive(1'b1, 10'h010, 8'h00, 5'd5, 5'd1, 5'd0);
    #1;
`ifdef CTRL_PIPE_LOADUSE_EN
    exp_lw = 1'b1;
`else
    exp_lw = 1'b0;
`endif
    chk("lu_r5_lwstall", {31'd0, lwstall}, {31'd0, exp_lw});
    step();
    chk("lu_r5_valid_e", {31'd0, valid_e}, {31'd0, ~exp_lw});
    chk("lu_r5_wreg_m", {27'd0, writereg_m}, 32'd5);
    // load writing r0 never triggers
    drive(1'b1, 10'h210, 8'h00, 5'd0, 5'd0, 5'd0);
    step();
    drive(1'b1, 10'h010, 8'h00, 5'd0, 5'd0, 5'd0);
    #1;
    chk("lu_r0_lwstall", {31'd0, lwstall}, 32'd0);
    step();
    chk("lu_r0_valid_e", {31'd0, valid_e}, 32'd1);

    // reset asserted mid-stall/flush clears everything before the next edge
    drive(1'b1, 10'h010, 8'h00, 5'd0, 5'd3, 5'd0);
    step();
    drive(1'b1, 10'h034, 8'h00, 5'd0, 5'd8, 5'd0);
    step();
    stall_e = 1'b1; flush_w = 1'b1;
    #1 rst = 1'b1;
    #1 check_all_zero("midrst");
    step();
    rst = 1'b0; stall_e = 1'b0; flush_w = 1'b0;
    drive(1'b1, 10'h010, 8'h00, 5'd0, 5'd9, 5'd0);
    step();
    chk("postrst_valid_e", {31'd0, valid_e}, 32'd1);
    chk("postrst_wreg_e", {27'd0, writereg_e}, 32'd9);
    chk("postrst_valid_m", {31'd0, valid_m}, 32'd0);
    chk("postrst_valid_w", {31'd0, valid_w}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
